// File: rtl/mips_bus_arbiter_if.sv
// rtl/mips_bus_arbiter_if.sv - instruction/data ports and Avalon master bundle for mips_bus_arbiter
// master = arbiter view, slave = CPU/memory environment view.
interface mips_bus_arbiter_if;
  logic [31:0] i_address;
  logic        i_read;
  logic        i_waitrequest;
  logic [31:0] i_readdata;

  logic [31:0] d_address;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic        d_waitrequest;
  logic [31:0] d_readdata;

  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    input  i_address, i_read, d_address, d_read, d_write, d_writedata, d_byteenable,
    input  waitrequest, readdata,
    output i_waitrequest, i_readdata, d_waitrequest, d_readdata,
    output address, read, write, writedata, byteenable
  );

  modport slave (
    output i_address, i_read, d_address, d_read, d_write, d_writedata, d_byteenable,
    output waitrequest, readdata,
    input  i_waitrequest, i_readdata, d_waitrequest, d_readdata,
    input  address, read, write, writedata, byteenable
  );
endinterface

// File: rtl/mips_bus_arbiter.sv
// rtl/mips_bus_arbiter.sv - arbitrates MIPS instruction and data ports onto one Avalon master
// Optional ARB_ROUND_ROBIN_EN: round-robin tie-break; otherwise data port always wins ties.
module mips_bus_arbiter (
  input  logic               clk,
  input  logic               reset,
  mips_bus_arbiter_if.master bus,
  output logic [1:0]         grant,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_t;

  state_t     state_q;
  logic [1:0] grant_q;
  logic       pend_i;
  logic       pend_d;
  logic       tie_to_d;

  assign pend_i = bus.i_read;
  assign pend_d = bus.d_read | bus.d_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q;  // 1 = data port completed the most recent transaction
  assign tie_to_d = ~last_d_q;
`else
  assign tie_to_d = 1'b1;
`endif

  // A granted port leaves on completion (request high, no wait) or on abort (request dropped).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pend_d && (tie_to_d || !pend_i)) begin
            state_q <= GNT_D;
            grant_q <= 2'b10;
          end else if (pend_i) begin
            state_q <= GNT_I;
            grant_q <= 2'b01;
          end
        end
        GNT_I: begin
          if (!pend_i || !bus.waitrequest) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
            if (pend_i) last_d_q <= 1'b0;
`endif
          end
        end
        GNT_D: begin
          if (!pend_d || !bus.waitrequest) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
            if (pend_d) last_d_q <= 1'b1;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign busy  = |grant_q;

  always_comb begin
    bus.address       = 32'h0;
    bus.read          = 1'b0;
    bus.write         = 1'b0;
    bus.writedata     = 32'h0;
    bus.byteenable    = 4'b0000;
    bus.i_waitrequest = 1'b1;
    bus.d_waitrequest = 1'b1;
    case (state_q)
      GNT_I: begin
        bus.address       = bus.i_address;
        bus.read          = bus.i_read;
        bus.byteenable    = 4'b1111;
        bus.i_waitrequest = bus.waitrequest;
      end
      GNT_D: begin
        bus.address       = bus.d_address;
        bus.write         = bus.d_write;
        bus.read          = bus.d_read & ~bus.d_write;  // write wins a read/write conflict
        bus.writedata     = bus.d_writedata;
        bus.byteenable    = bus.d_byteenable;
        bus.d_waitrequest = bus.waitrequest;
      end
      default: ;
    endcase
  end

  assign bus.i_readdata = bus.readdata;
  assign bus.d_readdata = bus.readdata;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb/tb_mips_bus_arbiter.sv - directed and randomized self-checking bench for mips_bus_arbiter
// Honours ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mips_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] grant;
  logic       busy;

  mips_bus_arbiter_if bus ();

  mips_bus_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .grant (grant),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: who owns the bus (0 none, 1 instr, 2 data) and who was served last.
  int owner;
  int last_served;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_address    = 32'h0;
    bus.i_read       = 1'b0;
    bus.d_address    = 32'h0;
    bus.d_read       = 1'b0;
    bus.d_write      = 1'b0;
    bus.d_writedata  = 32'h0;
    bus.d_byteenable = 4'h0;
    bus.waitrequest  = 1'b0;
    bus.readdata     = 32'h0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    owner       = 0;
    last_served = 1;
  endtask

  function automatic int tie_winner();
`ifdef ARB_ROUND_ROBIN_EN
    return (last_served == 1) ? 2 : 1;
`else
    return 2;
`endif
  endfunction

  task automatic model_check_outputs();
    logic [31:0] e_addr, e_wd;
    logic        e_rd, e_wr, e_iw, e_dw;
    logic [3:0]  e_be;
    logic [1:0]  e_gnt;
    e_addr = 32'h0; e_wd = 32'h0; e_rd = 1'b0; e_wr = 1'b0; e_be = 4'h0;
    e_iw = 1'b1; e_dw = 1'b1; e_gnt = 2'b00;
    if (owner == 1) begin
      e_gnt = 2'b01; e_addr = bus.i_address; e_rd = bus.i_read; e_be = 4'hF;
      e_iw = bus.waitrequest;
    end else if (owner == 2) begin
      e_gnt = 2'b10; e_addr = bus.d_address; e_wr = bus.d_write;
      e_rd = bus.d_read && !bus.d_write; e_wd = bus.d_writedata; e_be = bus.d_byteenable;
      e_dw = bus.waitrequest;
    end
    check("rnd_grant",  32'(grant), 32'(e_gnt));
    check("rnd_busy",   32'(busy), 32'(owner != 0));
    check("rnd_addr",   bus.address, e_addr);
    check("rnd_read",   32'(bus.read), 32'(e_rd));
    check("rnd_write",  32'(bus.write), 32'(e_wr));
    check("rnd_wdata",  bus.writedata, e_wd);
    check("rnd_be",     32'(bus.byteenable), 32'(e_be));
    check("rnd_i_wait", 32'(bus.i_waitrequest), 32'(e_iw));
    check("rnd_d_wait", 32'(bus.d_waitrequest), 32'(e_dw));
    check("rnd_i_rdata", bus.i_readdata, bus.readdata);
    check("rnd_d_rdata", bus.d_readdata, bus.readdata);
  endtask

  task automatic model_advance();
    bit pi, pd;
    pi = bus.i_read;
    pd = bus.d_read || bus.d_write;
    if (owner == 0) begin
      if (pi && pd)  owner = tie_winner();
      else if (pd)   owner = 2;
      else if (pi)   owner = 1;
    end else begin
      bit req;
      req = (owner == 1) ? pi : pd;
      if (!req) owner = 0;
      else if (!bus.waitrequest) begin
        last_served = owner;
        owner = 0;
      end
    end
  endtask

  logic [1:0] tie_seq [8];

  initial begin
    idle_inputs();
    reset = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_read", 32'(bus.read), 32'h0);
    check("rst_write", 32'(bus.write), 32'h0);
    check("rst_i_wait", 32'(bus.i_waitrequest), 32'h1);
    check("rst_d_wait", 32'(bus.d_waitrequest), 32'h1);
    apply_reset();

    // Single instruction fetch with no wait states
    bus.i_read = 1'b1; bus.i_address = 32'hBFC0_0000; bus.readdata = 32'h2402_0005;
    #1;
    check("fetch_c0_grant", 32'(grant), 32'h0);
    check("fetch_c0_i_wait", 32'(bus.i_waitrequest), 32'h1);
    tick();
    check("fetch_c1_grant", 32'(grant), 32'h1);
    check("fetch_c1_addr", bus.address, 32'hBFC0_0000);
    check("fetch_c1_read", 32'(bus.read), 32'h1);
    check("fetch_c1_i_wait", 32'(bus.i_waitrequest), 32'h0);
    check("fetch_c1_i_rdata", bus.i_readdata, 32'h2402_0005);
    tick();
    check("fetch_c2_grant", 32'(grant), 32'h0);
    bus.i_read = 1'b0;

    // Data write with three wait states
    bus.d_write = 1'b1; bus.d_address = 32'h1000; bus.d_writedata = 32'hDEAD_BEEF;
    bus.d_byteenable = 4'hF; bus.waitrequest = 1'b1;
    tick();
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) tick();
      if (c == 4) bus.waitrequest = 1'b0;
      #1;
      check("wr_write", 32'(bus.write), 32'h1);
      check("wr_addr", bus.address, 32'h1000);
      check("wr_wdata", bus.writedata, 32'hDEAD_BEEF);
      check("wr_be", 32'(bus.byteenable), 32'hF);
      check("wr_d_wait", 32'(bus.d_waitrequest), (c == 4) ? 32'h0 : 32'h1);
      check("wr_i_wait", 32'(bus.i_waitrequest), 32'h1);
    end
    tick();
    check("wr_done_grant", 32'(grant), 32'h0);

    // Continuous tie between both ports, starting from reset history
    apply_reset();
`ifdef ARB_ROUND_ROBIN_EN
    tie_seq = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
`else
    tie_seq = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
`endif
    bus.i_read = 1'b1; bus.d_read = 1'b1; bus.waitrequest = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("tie_grant", 32'(grant), 32'(tie_seq[k]));
    end

    // Asynchronous reset in the middle of a stalled data write
    idle_inputs();
    tick();
    tick();
    bus.d_write = 1'b1; bus.waitrequest = 1'b1;
    tick();
    check("arst_pre_write", 32'(bus.write), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_write", 32'(bus.write), 32'h0);
    check("arst_grant", 32'(grant), 32'h0);
    check("arst_i_wait", 32'(bus.i_waitrequest), 32'h1);
    check("arst_d_wait", 32'(bus.d_waitrequest), 32'h1);
    apply_reset();

    // Read/write conflict followed by an abort while stalled
    bus.d_read = 1'b1; bus.d_write = 1'b1; bus.waitrequest = 1'b1;
    tick();
    check("conf_grant", 32'(grant), 32'h2);
    check("conf_write", 32'(bus.write), 32'h1);
    check("conf_read", 32'(bus.read), 32'h0);
    bus.d_read = 1'b0; bus.d_write = 1'b0;
    #1;
    check("abort_d_wait", 32'(bus.d_waitrequest), 32'h1);
    tick();
    check("abort_grant", 32'(grant), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);

    // Randomized traffic against the reference model
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      bus.i_read       = ($urandom_range(0, 99) < 60);
      bus.d_read       = ($urandom_range(0, 99) < 45);
      bus.d_write      = ($urandom_range(0, 99) < 30);
      bus.waitrequest  = ($urandom_range(0, 99) < 40);
      bus.i_address    = $urandom;
      bus.d_address    = $urandom;
      bus.d_writedata  = $urandom;
      bus.d_byteenable = 4'($urandom_range(0, 15));
      bus.readdata     = $urandom;
      #1;
      model_check_outputs();
      model_advance();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
